// File: rtl/multiply_shift_add_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multiply_shift_add_pkg                                             |
// | Shared width constants and control-state encoding for the          |
// | iterative shift-and-add multiplier.                                |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package multiply_shift_add_pkg;

    localparam int MUL_W = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/multiply_shift_add_abs_sign.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multiply_shift_add_abs_sign                                        |
// | Splits a two's complement operand into an unsigned magnitude and   |
// | a sign bit.                                                        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module multiply_shift_add_abs_sign
    import multiply_shift_add_pkg::*;
#(
    parameter int WIDTH = MUL_W
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] magnitude,
    output logic             negative
);

    // Magnitude is read as unsigned, so the most negative input maps to 2^(WIDTH-1).
    assign negative  = value[WIDTH-1];
    assign magnitude = negative ? (~value + 1'b1) : value;

endmodule
`default_nettype wire

// File: rtl/multiply_shift_add.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | multiply_shift_add                                                 |
// | Iterative signed WIDTH x WIDTH -> 2*WIDTH multiplier, one          |
// | partial-product step per clock, level-based begin/end handshake.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module multiply_shift_add
    import multiply_shift_add_pkg::*;
#(
    parameter int WIDTH = MUL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mult_begin,
    input  logic [WIDTH-1:0]     mult_op1,
    input  logic [WIDTH-1:0]     mult_op2,
    output logic [2*WIDTH-1:0]   product,
    output logic                 mult_end
);

    localparam logic [CNT_W-1:0] c_last_step = CNT_W'(WIDTH - 1);

    state_t               r_state;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_count;
    logic                 r_sign;

    logic [WIDTH-1:0]     w_mag1;
    logic [WIDTH-1:0]     w_mag2;
    logic                 w_neg1;
    logic                 w_neg2;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_sum;
    logic [2*WIDTH-1:0]   w_result;

    multiply_shift_add_abs_sign #(.WIDTH(WIDTH)) u_abs_op1 (
        .value     (mult_op1),
        .magnitude (w_mag1),
        .negative  (w_neg1)
    );

    multiply_shift_add_abs_sign #(.WIDTH(WIDTH)) u_abs_op2 (
        .value     (mult_op2),
        .magnitude (w_mag2),
        .negative  (w_neg2)
    );

    assign w_addend  = r_mplier[0] ? r_mcand : '0;
    assign w_acc_sum = r_acc + w_addend;
    // Negating zero yields zero, so a zero product never carries a sign.
    assign w_result  = r_sign ? (~w_acc_sum + 1'b1) : w_acc_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_sign   <= 1'b0;
            product  <= '0;
            mult_end <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    mult_end <= 1'b0;
                    if (mult_begin) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_mag1};
                        r_mplier <= w_mag2;
                        r_sign   <= w_neg1 ^ w_neg2;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (!mult_begin) begin
                        r_state <= IDLE;
                    end else begin
                        r_acc    <= w_acc_sum;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + 1'b1;
                        if (r_count == c_last_step) begin
                            product  <= w_result;
                            mult_end <= 1'b1;
                            r_state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Holding here until the requester drops begin prevents a re-trigger.
                    if (!mult_begin) begin
                        mult_end <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    mult_end <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multiply_shift_add.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_multiply_shift_add                                              |
// | Directed and random self-checking bench for multiply_shift_add.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_multiply_shift_add;

    logic        clk = 1'b0;
    logic        rst;
    logic        mult_begin;
    logic [31:0] mult_op1;
    logic [31:0] mult_op2;
    logic [63:0] product;
    logic        mult_end;

    int total = 0;
    int bad   = 0;

    multiply_shift_add #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mult_begin (mult_begin),
        .mult_op1   (mult_op1),
        .mult_op2   (mult_op2),
        .product    (product),
        .mult_end   (mult_end)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // One full transaction: raise begin, measure latency, hold, drop, check hold-over.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int hold, input int gap,
                          input bit scramble);
        int n;
        @(negedge clk);
        mult_op1   = a;
        mult_op2   = b;
        mult_begin = 1'b1;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (scramble && n == 3) begin
                mult_op1 = ~a;
                mult_op2 = a ^ b ^ 32'h5A5A_A5A5;
            end
            if (mult_end) break;
        end
        check({tag, " latency"}, 64'(n), 64'd33);
        check({tag, " product"}, product, exp);
        for (int i = n; i < hold; i++) @(posedge clk);
        #1;
        check({tag, " end held"}, 64'(mult_end), 64'd1);
        check({tag, " product stable"}, product, exp);
        @(negedge clk);
        mult_begin = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " end dropped"}, 64'(mult_end), 64'd0);
        check({tag, " product kept"}, product, exp);
        repeat (gap) @(posedge clk);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [63:0] rexp;
        bit          seen_end;

        rst        = 1'b1;
        mult_begin = 1'b0;
        mult_op1   = '0;
        mult_op2   = '0;
        #1;
        check("reset product", product, 64'd0);
        check("reset end", 64'(mult_end), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        run_op("1111x1111", 32'h0000_1111, 32'h0000_1111, 64'h0000_0000_0123_4321, 40, 50, 1'b1);
        run_op("1111x2222", 32'h0000_1111, 32'h0000_2222, 64'h0000_0000_0246_8642, 40, 50, 1'b0);
        run_op("2xneg1",    32'h0000_0002, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 40, 50, 1'b1);
        run_op("2xmin",     32'h0000_0002, 32'h8000_0000, 64'hFFFF_FFFF_0000_0000, 40, 50, 1'b0);
        run_op("minxmin",   32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 40, 50, 1'b0);
        run_op("neg1xneg1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 40, 50, 1'b0);
        run_op("zeroxneg5", 32'h0000_0000, 32'hFFFF_FFFB, 64'h0000_0000_0000_0000, 40, 50, 1'b0);
        run_op("maxxmax",   32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 40, 50, 1'b0);
        run_op("neg3x7",    32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 40, 50, 1'b0);

        // Abort at RUN cycle 10: result never appears and the previous product survives.
        @(negedge clk);
        mult_op1   = 32'h0000_0005;
        mult_op2   = 32'h0000_0007;
        mult_begin = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        mult_begin = 1'b0;
        seen_end = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            seen_end |= mult_end;
        end
        check("abort no end", 64'(seen_end), 64'd0);
        check("abort product kept", product, 64'hFFFF_FFFF_FFFF_FFEB);

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        mult_begin = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async rst product", product, 64'd0);
        check("async rst end", 64'(mult_end), 64'd0);
        @(negedge clk);
        rst        = 1'b0;
        mult_begin = 1'b0;
        seen_end = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen_end |= mult_end;
        end
        check("post rst no end", 64'(seen_end), 64'd0);
        check("post rst product", product, 64'd0);

        run_op("recover", 32'h0000_1111, 32'h0000_2222, 64'h0000_0000_0246_8642, 40, 50, 1'b0);

        for (int k = 0; k < 200; k++) begin
            ra   = $urandom;
            rb   = $urandom;
            rexp = 64'(longint'(int'(ra)) * longint'(int'(rb)));
            run_op("random", ra, rb, rexp, 0, 1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
